// File: rtl/mux_scan_ctrl.sv
// Mux scan controller: walks a downstream 4:1 mux select through ch0..ch3, dwelling
// DWELL cycles per channel, then hands the sampled 4-bit frame out over valid/ready.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] sel,
  input  logic       mux_f,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] cap_q, cap_d;
  logic [3:0] frame_q, frame_d;
  logic       fv_q, fv_d;
  logic       busy_q, busy_d;
  logic       dwell_done;
  logic       handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'b00;
      cnt_q   <= 4'd0;
      cap_q   <= 3'b000;
      frame_q <= 4'b0000;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
    end
  end

  assign dwell_done = (cnt_q == DWELL_LAST);
  assign handshake  = fv_q && frame_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    frame_d = frame_q;
    fv_d    = fv_q;
    busy_d  = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          sel_d   = 2'b00;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end

      ST_SCAN: begin
        if (dwell_done) begin
          cnt_d = 4'd0;
          if (sel_q == 2'b11) begin
            // ch3 goes straight into the frame; it never needs a capture bit.
            frame_d = {mux_f, cap_q};
            fv_d    = 1'b1;
            sel_d   = 2'b00;
            state_d = ST_OUTPUT;
          end else begin
            cap_d[sel_q] = mux_f;
            sel_d        = sel_q + 2'b01;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_OUTPUT: begin
        if (handshake) begin
          fv_d = 1'b0;
          if (start) begin
            // Back-to-back scan: skip IDLE entirely.
            state_d = ST_SCAN;
            sel_d   = 2'b00;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'b00;
        cnt_d   = 4'd0;
        fv_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sel         = sel_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scenarios plus randomized scans against a
// channel-history model, on DWELL=2, DWELL=1 and DWELL=16 instances.
module tb_mux_scan_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, ready_a = 1'b0, fv_a, busy_a, muxf_a;
  logic [1:0] sel_a;
  logic [3:0] frame_a, ch_a = 4'b0000;
  logic       start_b = 1'b0, ready_b = 1'b0, fv_b, busy_b, muxf_b;
  logic [1:0] sel_b;
  logic [3:0] frame_b, ch_b = 4'b0000;
  logic       start_c = 1'b0, ready_c = 1'b0, fv_c, busy_c, muxf_c;
  logic [1:0] sel_c;
  logic [3:0] frame_c, ch_c = 4'b0000;

  // Model 4:1 muxes feeding each controller.
  assign muxf_a = ch_a[sel_a];
  assign muxf_b = ch_b[sel_b];
  assign muxf_c = ch_c[sel_c];

  mux_scan_ctrl #(.DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sel(sel_a), .mux_f(muxf_a),
    .frame(frame_a), .frame_valid(fv_a), .frame_ready(ready_a), .busy(busy_a));
  mux_scan_ctrl #(.DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sel(sel_b), .mux_f(muxf_b),
    .frame(frame_b), .frame_valid(fv_b), .frame_ready(ready_b), .busy(busy_b));
  mux_scan_ctrl #(.DWELL(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .sel(sel_c), .mux_f(muxf_c),
    .frame(frame_c), .frame_valid(fv_c), .frame_ready(ready_c), .busy(busy_c));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge numbering: the edge that accepts start is edge 1. With dwell D, channel i
  // is sampled on edge 1+(i+1)*D, the frame appears on edge 4*D+1, and after edge
  // e (e<=4*D) the select shows channel (e-1)/D.
  logic [3:0] hist [0:15];
  logic [3:0] expf;
  logic [3:0] held;
  int         n;
  int         wait_n;
  bit         b2b;

  initial begin
    // Reset: outputs clear with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sel_a", sel_a, 0);
    chk("rst_fv_a", fv_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_frame_a", frame_a, 0);
    chk("rst_fv_b", fv_b, 0);
    chk("rst_busy_c", busy_c, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic scan, channels 1,0,1,1, frame_ready held high.
    ch_a = 4'b1101; ready_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("basic_sel", sel_a, (k - 1) / 2);
      chk("basic_fv_low", fv_a, 0);
      chk("basic_busy", busy_a, 1);
      if (k < 8) tick();
    end
    tick();
    chk("basic_fv_edge9", fv_a, 1);
    chk("basic_frame", frame_a, 4'b1101);
    chk("basic_sel_out", sel_a, 0);
    tick();
    chk("basic_fv_one_cycle", fv_a, 0);
    chk("basic_idle_busy", busy_a, 0);
    chk("basic_frame_kept", frame_a, 4'b1101);

    // Consumer stalls for 5 cycles; start pulses in OUTPUT are ignored.
    ch_a = 4'b0110; ready_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (8) tick();
    chk("stall_fv_rise", fv_a, 1);
    chk("stall_frame", frame_a, 4'b0110);
    for (int w = 0; w < 5; w++) begin
      start_a = (w % 2 == 0);
      ch_a = ~ch_a;
      tick();
      chk("stall_fv_hold", fv_a, 1);
      chk("stall_frame_hold", frame_a, 4'b0110);
      chk("stall_busy", busy_a, 1);
    end
    start_a = 1'b0; ready_a = 1'b1;
    tick();
    chk("stall_release_fv", fv_a, 0);
    chk("stall_release_idle", busy_a, 0);

    // start held high: two back-to-back scans, 0000 then 1010, busy never drops.
    ch_a = 4'b0000; start_a = 1'b1; ready_a = 1'b1;
    tick();
    for (int e = 2; e <= 18; e++) begin
      if (e == 10) ch_a = 4'b1010;
      tick();
      chk("b2b_busy", busy_a, 1);
      chk("b2b_fv", fv_a, (e == 9 || e == 18) ? 1 : 0);
      if (e == 9)  chk("b2b_frame0", frame_a, 4'b0000);
      if (e == 18) chk("b2b_frame1", frame_a, 4'b1010);
    end
    start_a = 1'b0;
    tick();
    chk("b2b_end_idle", busy_a, 0);

    // Randomized scans: channel inputs change every cycle, start and frame_ready toggle.
    b2b = 1'b0;
    for (int s = 0; s < 20; s++) begin
      if (!b2b) begin
        start_a = 1'b1;
        tick();
      end
      for (int e = 2; e <= 9; e++) begin
        ch_a    = 4'($urandom_range(0, 15));
        hist[e] = ch_a;
        start_a = 1'($urandom_range(0, 1));
        ready_a = 1'($urandom_range(0, 1));
        tick();
        chk("rnd_sel", sel_a, (e < 9) ? (e - 1) / 2 : 0);
        chk("rnd_fv", fv_a, (e == 9) ? 1 : 0);
        chk("rnd_busy", busy_a, 1);
      end
      for (int i = 0; i < 4; i++) begin
        held    = hist[1 + (i + 1) * 2];
        expf[i] = held[i];
      end
      chk("rnd_frame", frame_a, expf);
      wait_n  = $urandom_range(0, 3);
      ready_a = 1'b0;
      for (int w = 0; w < wait_n; w++) begin
        start_a = 1'($urandom_range(0, 1));
        tick();
        chk("rnd_hold_fv", fv_a, 1);
        chk("rnd_hold_frame", frame_a, expf);
      end
      b2b     = (s == 19) ? 1'b0 : 1'($urandom_range(0, 1));
      start_a = b2b;
      ready_a = 1'b1;
      tick();
      chk("rnd_hs_fv", fv_a, 0);
      chk("rnd_hs_busy", busy_a, b2b);
      start_a = 1'b0;
    end

    // Asynchronous reset in the middle of a scan at sel=10.
    ch_a = 4'b1011; ready_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    chk("arst_sel_pre", sel_a, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sel", sel_a, 0);
    chk("arst_fv", fv_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_frame", frame_a, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("arst_no_frame", fv_a, 0);
      chk("arst_stay_idle", busy_a, 0);
    end

    // First start after reset runs a normal scan.
    ch_a = 4'b1001; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (8) tick();
    chk("post_rst_fv", fv_a, 1);
    chk("post_rst_frame", frame_a, 4'b1001);
    tick();
    chk("post_rst_idle", busy_a, 0);

    // DWELL=1 build: frame on edge 5.
    ch_b = 4'b1111; ready_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 1;
    while (fv_b !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("dw1_latency", n, 5);
    chk("dw1_frame", frame_b, 4'b1111);

    // DWELL=16 build: frame on edge 65.
    ch_c = 4'b1111; ready_c = 1'b1; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    n = 1;
    while (fv_c !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("dw16_latency", n, 65);
    chk("dw16_frame", frame_c, 4'b1111);
    tick();
    chk("dw16_idle", busy_c, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, default 2, the number of clock cycles each mux channel is selected before its output is sampled; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request one 4-channel scan; level-sampled.
REQ-005 sel  output  2  channel select driven to the downstream 4:1 mux (00=ch0 .. 11=ch3).
REQ-006 mux_f  input  1  mux output returned for the currently selected channel.
REQ-007 frame  output  4  completed scan result; bit[i] = mux_f sampled while sel==i.
REQ-008 frame_valid  output  1  frame holds a new, unconsumed result.
REQ-009 frame_ready  input  1  consumer accepts frame when high together with frame_valid.
REQ-010 busy  output  1  high while a scan is in progress or a frame is awaiting acceptance.

Function
REQ-011 Three-state FSM: IDLE, SCAN, OUTPUT; all outputs are registered.
REQ-012 IDLE: sel=00, frame_valid=0, busy=0; on a rising edge with start=1, transition to SCAN with sel=00 and dwell counter=0.
REQ-013 SCAN: dwell counter (4-bit) increments every cycle; at the edge where counter==DWELL-1, mux_f is captured into internal capture bit[sel] and the counter returns to 0.
REQ-014 SCAN, same edge, sel!=11: sel increments by 1 and the FSM stays in SCAN.
REQ-015 SCAN, same edge, sel==11: frame is loaded with {mux_f, capture[2:0]}, frame_valid becomes 1, sel returns to 00, and the FSM transitions to OUTPUT.
REQ-016 Latency: frame_valid rises exactly 4*DWELL+1 rising edges after the edge that accepted start (DWELL=2 gives 9).
REQ-017 OUTPUT: frame and frame_valid are held stable until a handshake edge with frame_valid=1 and frame_ready=1.
REQ-018 Handshake edge with start=0: frame_valid becomes 0 and the FSM transitions to IDLE; frame keeps its last value.
REQ-019 Handshake edge with start=1: frame_valid becomes 0 and the FSM enters SCAN directly with sel=00 and counter=0, i.e. back-to-back scans with no IDLE cycle.
REQ-020 start is ignored in SCAN, and in OUTPUT except on the handshake edge; no request queueing.
REQ-021 frame_ready while frame_valid=0 has no effect.
REQ-022 busy is 1 in SCAN and OUTPUT and 0 in IDLE.
REQ-023 The capture register is not cleared between scans; every bit is overwritten by each scan before frame is loaded.
REQ-024 DWELL=1: sel advances every cycle and the frame becomes available 5 edges after start.

Reset
REQ-025 While rst_n=0, immediately and independently of clk: state=IDLE, sel=00, counter=0, capture=0000, frame=0000, frame_valid=0, busy=0.
REQ-026 Reset asserted mid-SCAN or in OUTPUT aborts the operation; no partial or pending frame is presented after release.
REQ-027 After rst_n deasserts, the first edge with start=1 starts a scan normally.

Verification
REQ-028 DWELL=2; mux_f follows a model mux with channel inputs ch0..ch3=1,0,1,1; pulse start, hold frame_ready=1 -> sel steps 00,00,01,01,10,10,11,11; frame=4'b1101; frame_valid high for exactly one cycle, on edge 9.
REQ-029 frame_ready=0 for 5 cycles after frame_valid rises -> frame and frame_valid stay constant, busy=1; start pulses during the wait are ignored; raising frame_ready gives IDLE on the next edge.
REQ-030 start held high continuously, channel inputs changed between scans (0000 then 1010) -> two back-to-back frames, 0000 then 1010, with no IDLE cycle between them.
REQ-031 rst_n pulled low asynchronously mid-scan at sel=10 -> all outputs reset without a clock edge; no frame_valid after release until a new start.
REQ-032 DWELL=1 and DWELL=16 builds, each scanning all inputs = 1 -> frame=1111 with frame_valid rising exactly 5 and 65 edges after start, respectively.
